// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states, iteration counter width.
// Helpers classify an opcode as divide and/or signed.
package muldiv_pkg;
    localparam int MD_WIDTH = 32;
    localparam int ITER_W   = $clog2(MD_WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FIXUP = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return !op[0];
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// EX-stage request/response bundle of the multiply/divide unit, including MTHI/MTLO writes and flush.
// master = issuing pipeline, slave = muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             flush;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, A, B, hi_we, lo_we, wdata, flush,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we, wdata, flush,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply on {hi_part,lo_part}, or restoring divide step
// on {rem,quot}; operand is the multiplicand or the divisor magnitude.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_part,
    input  logic [WIDTH-1:0] lo_part,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, hi_part} + (lo_part[0] ? {1'b0, operand} : '0);
        rem_sh  = {hi_part, lo_part[WIDTH-1]};
        // rem_sh < 2*operand always, so the top bit of diff is a clean borrow flag
        diff    = rem_sh - {1'b0, operand};
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo_part[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {lo_part[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = rem_sh[WIDTH-1:0];
                lo_next = {lo_part[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; result WIDTH+1 cycles after accept, done one cycle later.
// Starts while busy are dropped (no queueing); flush cancels without touching HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam logic [ITER_W-1:0] LAST = ITER_W'(WIDTH - 1);

    state_e             state, state_next;
    logic [ITER_W-1:0]  count;
    op_e                op_q;
    logic               sign_a, sign_b, b_zero;
    logic [WIDTH-1:0]   a_orig, acc, low, opnd;
    logic [WIDTH-1:0]   acc_step, low_step;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;
    logic               accept, finish, wr_ok;

    op_e                op_in;
    logic               sgn_in;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, hi_fin, lo_fin;

    assign op_in  = op_e'(bus.op);
    assign sgn_in = op_is_signed(op_in);
    assign a_abs  = (sgn_in && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_abs  = (sgn_in && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_is_div(op_q)),
        .hi_part (acc),
        .lo_part (low),
        .operand (opnd),
        .hi_next (acc_step),
        .lo_next (low_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        wr_ok      = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.flush) begin
                    if (bus.start) begin
                        accept     = 1'b1;
                        state_next = RUN;
                    end else begin
                        wr_ok = 1'b1;
                    end
                end
            end
            RUN:     if (count == LAST) state_next = FIXUP;
            FIXUP: begin
                finish     = !bus.flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    // Sign restoration; the 0x80000000 / -1 case falls out naturally from magnitude arithmetic
    always_comb begin
        prod_fix = {acc, low};
        if (op_q == OP_MULT && (sign_a ^ sign_b)) prod_fix = -{acc, low};
        quot_fix = (op_q == OP_DIV && (sign_a ^ sign_b)) ? -low : low;
        rem_fix  = (op_q == OP_DIV && sign_a) ? -acc : acc;
        if (!op_is_div(op_q)) begin
            hi_fin = prod_fix[2*WIDTH-1:WIDTH];
            lo_fin = prod_fix[WIDTH-1:0];
        end else if (b_zero) begin
            hi_fin = a_orig;
            lo_fin = '1;
        end else begin
            hi_fin = rem_fix;
            lo_fin = quot_fix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            op_q   <= OP_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
            a_orig <= '0;
            acc    <= '0;
            low    <= '0;
            opnd   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= finish;
            if (accept) begin
                op_q   <= op_in;
                sign_a <= sgn_in & bus.A[WIDTH-1];
                sign_b <= sgn_in & bus.B[WIDTH-1];
                b_zero <= (bus.B == '0);
                a_orig <= bus.A;
                acc    <= '0;
                low    <= op_is_div(op_in) ? a_abs : b_abs;
                opnd   <= op_is_div(op_in) ? b_abs : a_abs;
                count  <= '0;
                dbz_q  <= 1'b0;
            end else if (state == RUN) begin
                acc   <= acc_step;
                low   <= low_step;
                count <= count + 1'b1;
            end
            if (finish) begin
                hi_q <= hi_fin;
                lo_q <= lo_fin;
                if (op_is_div(op_q) && b_zero) dbz_q <= 1'b1;
            end else if (wr_ok) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide engine for the MIPS-PPU EX stage. It covers MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Acts as the sequential counterpart of the single-cycle ALU. The EX stage issues A/B/op into it and holds dependent MFHI/MFLO instructions until done.
- Owns the architectural HI/LO registers.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  in  WIDTH  multiplicand / dividend
- B  in  WIDTH  multiplier / divisor
- hi_we  in  1  MTHI write strobe
- lo_we  in  1  MTLO write strobe
- wdata  in  WIDTH  MTHI/MTLO data
- flush  in  1  synchronous cancel of the in-flight operation
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- div_by_zero  out  1  sticky until next accepted start; set on DIV/DIVU with B==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, count=0.
- States and transitions:
  - IDLE: start=1 → RUN. At accept, latch op, |A|, |B| (signed ops only; unsigned pass through), sign_a, sign_b, original A. Clear count and div_by_zero.
  - RUN: one iteration per cycle. Multiply is shift-add on {acc,mplier}. Divide is restoring: shift {rem,quot} left by 1, trial-subtract |B|, set quot LSB on no-borrow. count increments; at count==WIDTH-1 → FIXUP.
  - FIXUP:
    - Signed MULT with sign_a^sign_b: negate the 2*WIDTH product.
    - Signed DIV: negate quotient if sign_a^sign_b; remainder takes the sign of the dividend.
    - Write hi = upper/remainder, lo = lower/quotient. Register done=1. → IDLE.
- busy = (state != IDLE). done is registered and high only in the cycle after the FIXUP edge.
- Latency: start sampled at edge E0 of cycle T.
  - busy is high cycles T+1..T+WIDTH+1 (33 cycles).
  - HI/LO update at edge E(WIDTH+1).
  - done is high in cycle T+WIDTH+2 (T+34).
- Start while busy: ignored, no queueing. Start in the done cycle: accepted (state is IDLE).
- Divide by zero: keeps full latency. FIXUP forces lo = all ones, hi = original A (unsigned view), and sets div_by_zero=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag.
- hi_we/lo_we:
  - Honored only in IDLE with start=0; they write hi/lo at the edge.
  - Dropped while busy.
  - If start and a write occur in the same cycle, start wins and the write is dropped.
- flush:
  - Any state → IDLE at the next edge. hi/lo unchanged, done stays 0, div_by_zero keeps its value.
  - flush with start in IDLE: start is ignored.
- Reset mid-operation: all state is cleared immediately. No done is produced.
- HI/LO change only at FIXUP, on accepted writes, or on reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU
  - state enum IDLE/RUN/FIXUP
  - ITER_W = clog2(WIDTH)
- One combinational sub-module, muldiv_step: a single multiply or divide iteration on {hi_part, lo_part, operand}, selected by an is_div input.
- Top level holds the FSM, counter, sign fixup and the HI/LO registers.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, start at T → busy T+1..T+33; done only in T+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT A=-3 (0xFFFFFFFD), B=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV A=-7, B=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU A=100, B=0 → done at T+34; lo=0xFFFFFFFF, hi=100; div_by_zero=1. div_by_zero returns to 0 at the edge accepting the next start.
- Start MULTU 6*7; re-assert start with other operands at T+5; flush at T+10 → busy=0 from T+11; no done; hi/lo keep prior values. A fresh start at T+11 then completes with the correct result at T+45.
- hi_we with wdata=0x1234 in IDLE → hi=0x1234. hi_we while busy → hi unchanged. start+lo_we in the same cycle → operation runs, lo_we dropped.
- Assert reset at iteration 15 of a DIVU → busy, done, hi and lo go to 0 immediately. No done pulse follows.
